// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: carries fetch-time predictions through D and E,
// then drives the predictor update, the redirect/flush, and the perf counters.
module branch_resolve_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic             f_pred_taken,
    input  logic [31:0]      f_pred_pc,
    input  logic             stall_d,
    input  logic             stall_e,
    input  logic             e_is_branch,
    input  logic             e_actual_taken,
    input  logic [31:0]      e_actual_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             upd_bt,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [31:0]      upd_target,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             d_valid_q, d_valid_d;
    logic [31:0]      d_pc_q, d_pc_d;
    logic             d_pred_taken_q, d_pred_taken_d;
    logic [31:0]      d_pred_pc_q, d_pred_pc_d;
    logic             e_valid_q, e_valid_d;
    logic [31:0]      e_pc_q, e_pc_d;
    logic             e_pred_taken_q, e_pred_taken_d;
    logic [31:0]      e_pred_pc_q, e_pred_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic        ok;
    logic        br_mis;
    logic        alias_mis;
    logic        redirect_int;
    logic        upd_int;
    logic [31:0] e_pc_plus4;

    always_comb begin
        // rst gates resolution so nothing leaks out of a slot being dropped
        ok           = e_valid_q & ~stall_e & ~rst;
        e_pc_plus4   = e_pc_q + 32'd4;
        br_mis       = ok & e_is_branch &
                       ((e_pred_taken_q != e_actual_taken) |
                        (e_actual_taken & (e_pred_pc_q != e_actual_target)));
        alias_mis    = ok & ~e_is_branch & e_pred_taken_q;
        redirect_int = br_mis | alias_mis;
        upd_int      = ok & e_is_branch;

        redirect    = redirect_int;
        flush_fd    = redirect_int;
        flush_de    = redirect_int;
        redirect_pc = '0;
        if (redirect_int) begin
            redirect_pc = (br_mis & e_actual_taken) ? e_actual_target : e_pc_plus4;
        end

        upd_bt     = upd_int;
        upd_pc     = upd_int ? e_pc_q : '0;
        upd_taken  = upd_int & e_actual_taken;
        upd_target = upd_int ? e_actual_target : '0;

        br_cnt  = br_cnt_q;
        mis_cnt = mis_cnt_q;
    end

    always_comb begin
        d_valid_d      = d_valid_q;
        d_pc_d         = d_pc_q;
        d_pred_taken_d = d_pred_taken_q;
        d_pred_pc_d    = d_pred_pc_q;
        e_valid_d      = e_valid_q;
        e_pc_d         = e_pc_q;
        e_pred_taken_d = e_pred_taken_q;
        e_pred_pc_d    = e_pred_pc_q;

        // redirect outranks stall_d: the wrong-path fetch this cycle is dropped
        if (redirect_int) begin
            d_valid_d = 1'b0;
            e_valid_d = 1'b0;
        end else if (!stall_e) begin
            if (stall_d) begin
                e_valid_d = 1'b0;
            end else begin
                e_valid_d      = d_valid_q;
                e_pc_d         = d_pc_q;
                e_pred_taken_d = d_pred_taken_q;
                e_pred_pc_d    = d_pred_pc_q;
                d_valid_d      = f_valid;
                d_pc_d         = f_pc;
                d_pred_taken_d = f_pred_taken;
                d_pred_pc_d    = f_pred_pc;
            end
        end

        br_cnt_d = br_cnt_q;
        if (upd_int && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end
        mis_cnt_d = mis_cnt_q;
        if (redirect_int && (mis_cnt_q != CNT_MAX)) begin
            mis_cnt_d = mis_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid_q      <= 1'b0;
            d_pc_q         <= '0;
            d_pred_taken_q <= 1'b0;
            d_pred_pc_q    <= '0;
            e_valid_q      <= 1'b0;
            e_pc_q         <= '0;
            e_pred_taken_q <= 1'b0;
            e_pred_pc_q    <= '0;
            br_cnt_q       <= '0;
            mis_cnt_q      <= '0;
        end else begin
            d_valid_q      <= d_valid_d;
            d_pc_q         <= d_pc_d;
            d_pred_taken_q <= d_pred_taken_d;
            d_pred_pc_q    <= d_pred_pc_d;
            e_valid_q      <= e_valid_d;
            e_pc_q         <= e_pc_d;
            e_pred_taken_q <= e_pred_taken_d;
            e_pred_pc_q    <= e_pred_pc_d;
            br_cnt_q       <= br_cnt_d;
            mis_cnt_q      <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: behavioural slot/counter model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = '0;
    logic        f_pred_taken = 1'b0;
    logic [31:0] f_pred_pc = '0;
    logic        stall_d = 1'b0;
    logic        stall_e = 1'b0;
    logic        e_is_branch = 1'b0;
    logic        e_actual_taken = 1'b0;
    logic [31:0] e_actual_target = '0;

    logic        redirect, flush_fd, flush_de, upd_bt, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [15:0] br_cnt, mis_cnt;
    logic        redirect2, flush_fd2, flush_de2, upd_bt2, upd_taken2;
    logic [31:0] redirect_pc2, upd_pc2, upd_target2;
    logic [1:0]  br_cnt2, mis_cnt2;

    branch_resolve_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_pc(f_pred_pc),
        .stall_d(stall_d), .stall_e(stall_e),
        .e_is_branch(e_is_branch), .e_actual_taken(e_actual_taken), .e_actual_target(e_actual_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_fd(flush_fd), .flush_de(flush_de),
        .upd_bt(upd_bt), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    branch_resolve_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_pc(f_pred_pc),
        .stall_d(stall_d), .stall_e(stall_e),
        .e_is_branch(e_is_branch), .e_actual_taken(e_actual_taken), .e_actual_target(e_actual_target),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .flush_fd(flush_fd2), .flush_de(flush_de2),
        .upd_bt(upd_bt2), .upd_pc(upd_pc2), .upd_taken(upd_taken2), .upd_target(upd_target2),
        .br_cnt(br_cnt2), .mis_cnt(mis_cnt2)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two metadata slots and unbounded event counts
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [31:0] ppc;
    } slot_t;

    slot_t  md = '{v: 1'b0, pc: 32'd0, pt: 1'b0, ppc: 32'd0};
    slot_t  me = '{v: 1'b0, pc: 32'd0, pt: 1'b0, ppc: 32'd0};
    longint m_br  = 0;
    longint m_mis = 0;
    bit     checking = 1'b0;

    localparam longint MAX16 = 65535;
    localparam longint MAX2  = 3;

    function automatic longint sat(input longint c, input longint mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic void resolve(output bit ok, output bit mis, output bit [31:0] rpc);
        ok  = me.v && !stall_e && !rst;
        mis = 1'b0;
        rpc = 32'd0;
        if (ok && e_is_branch) begin
            if ((me.pt != e_actual_taken) || (e_actual_taken && (me.ppc != e_actual_target))) begin
                mis = 1'b1;
                rpc = e_actual_taken ? e_actual_target : me.pc + 32'd4;
            end
        end else if (ok && me.pt) begin
            mis = 1'b1;
            rpc = me.pc + 32'd4;
        end
    endfunction

    always @(posedge clk) begin
        bit        ok, mis;
        bit [31:0] rpc;
        resolve(ok, mis, rpc);
        if (rst) begin
            md.v  = 1'b0;
            me.v  = 1'b0;
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (ok && e_is_branch) m_br++;
            if (mis) m_mis++;
            if (mis) begin
                md.v = 1'b0;
                me.v = 1'b0;
            end else if (!stall_e) begin
                if (stall_d) begin
                    me.v = 1'b0;
                end else begin
                    me = md;
                    md = '{v: f_valid, pc: f_pc, pt: f_pred_taken, ppc: f_pred_pc};
                end
            end
        end
    end

    always @(negedge clk) begin
        bit        ok, mis, upd;
        bit [31:0] rpc;
        if (checking) begin
            resolve(ok, mis, rpc);
            upd = ok && e_is_branch;
            check("redirect",    64'(redirect),    64'(mis));
            check("flush_fd",    64'(flush_fd),    64'(mis));
            check("flush_de",    64'(flush_de),    64'(mis));
            check("redirect_pc", 64'(redirect_pc), 64'(rpc));
            check("upd_bt",      64'(upd_bt),      64'(upd));
            check("upd_pc",      64'(upd_pc),      64'(upd ? me.pc : 32'd0));
            check("upd_taken",   64'(upd_taken),   64'(upd && e_actual_taken));
            check("upd_target",  64'(upd_target),  64'(upd ? e_actual_target : 32'd0));
            check("br_cnt",      64'(br_cnt),      64'(sat(m_br, MAX16)));
            check("mis_cnt",     64'(mis_cnt),     64'(sat(m_mis, MAX16)));
            check("br_cnt_w2",   64'(br_cnt2),     64'(sat(m_br, MAX2)));
            check("mis_cnt_w2",  64'(mis_cnt2),    64'(sat(m_mis, MAX2)));
            check("w2_flags", 64'({redirect2, flush_fd2, flush_de2, upd_bt2, upd_taken2}),
                  64'({mis, mis, mis, upd, upd && e_actual_taken}));
            check("w2_redirect_pc", 64'(redirect_pc2), 64'(rpc));
            check("w2_upd_pc",      64'(upd_pc2),      64'(upd ? me.pc : 32'd0));
            check("w2_upd_target",  64'(upd_target2),  64'(upd ? e_actual_target : 32'd0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input bit v, input logic [31:0] pc, input bit pt, input logic [31:0] ppc);
        f_valid      = v;
        f_pc         = pc;
        f_pred_taken = pt;
        f_pred_pc    = ppc;
    endtask

    task automatic set_exec(input bit br, input bit tk, input logic [31:0] tgt);
        e_is_branch     = br;
        e_actual_taken  = tk;
        e_actual_target = tgt;
    endtask

    // Fetch one instruction, let it reach E, present the resolution, stop at the negedge
    task automatic to_e(input logic [31:0] pc, input bit pt, input logic [31:0] ppc,
                        input bit br, input bit tk, input logic [31:0] tgt);
        set_fetch(1'b1, pc, pt, ppc);
        step();
        set_fetch(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        set_exec(br, tk, tgt);
        @(negedge clk);
    endtask

    task automatic leave_e();
        step();
        set_exec(1'b0, 1'b0, 32'd0);
        @(negedge clk);
    endtask

    logic [31:0] pool [0:5];

    initial begin
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1004; pool[2] = 32'h0000_0080;
        pool[3] = 32'h0000_0084; pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h0000_2000;

        rst = 1'b1;
        @(posedge clk);
        checking = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_redirect", 64'(redirect), 64'd0);
        check("reset_upd_bt",   64'(upd_bt),   64'd0);
        check("reset_br_cnt",   64'(br_cnt),   64'd0);
        check("reset_mis_cnt",  64'(mis_cnt),  64'd0);

        to_e(32'h100, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80);
        check("t2_upd_bt",   64'(upd_bt),   64'd1);
        check("t2_upd_pc",   64'(upd_pc),   64'h100);
        check("t2_redirect", 64'(redirect), 64'd0);
        leave_e();
        check("t2_br_cnt",   64'(br_cnt),   64'd1);

        to_e(32'h200, 1'b0, 32'h204, 1'b1, 1'b1, 32'h240);
        check("t3_redirect",    64'(redirect),    64'd1);
        check("t3_redirect_pc", 64'(redirect_pc), 64'h240);
        check("t3_flushes",     64'({flush_fd, flush_de}), 64'd3);
        set_fetch(1'b1, 32'hA00, 1'b1, 32'hB00);
        step();
        set_fetch(1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        check("t3_after_redirect", 64'({redirect, upd_bt}), 64'd0);
        check("t3_mis_cnt",        64'(mis_cnt), 64'd1);
        check("t3_br_cnt",         64'(br_cnt),  64'd2);
        step();
        @(negedge clk);
        check("t3_wrong_path_dropped", 64'({redirect, upd_bt}), 64'd0);
        set_exec(1'b0, 1'b0, 32'd0);

        to_e(32'h280, 1'b1, 32'h300, 1'b1, 1'b1, 32'h310);
        check("t4_redirect_pc", 64'(redirect_pc), 64'h310);
        check("t4_upd_target",  64'(upd_target),  64'h310);
        leave_e();

        to_e(32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 32'd0);
        check("t5_redirect_pc", 64'(redirect_pc), 64'h404);
        check("t5_upd_bt",      64'(upd_bt),      64'd0);
        leave_e();
        check("t5_mis_cnt",     64'(mis_cnt),     64'd3);

        to_e(32'h500, 1'b0, 32'h504, 1'b1, 1'b1, 32'h540);
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_stalled", 64'({redirect, flush_fd, flush_de, upd_bt}), 64'd0);
            step();
        end
        stall_e = 1'b0;
        @(negedge clk);
        check("t6_redirect",    64'(redirect),    64'd1);
        check("t6_redirect_pc", 64'(redirect_pc), 64'h540);
        step();
        @(negedge clk);
        check("t6_once", 64'({redirect, upd_bt}), 64'd0);
        set_exec(1'b0, 1'b0, 32'd0);

        to_e(32'h600, 1'b1, 32'h700, 1'b1, 1'b1, 32'h710);
        leave_e();
        check("t7_mis_cnt",    64'(mis_cnt),  64'd5);
        check("t7_mis_cnt_w2", 64'(mis_cnt2), 64'd3);
        check("t7_br_cnt_w2",  64'(br_cnt2),  64'd3);

        for (int n = 0; n < 4000; n++) begin
            step();
            rst     = ($urandom_range(0, 99) == 0);
            stall_d = ($urandom_range(0, 4) == 0);
            stall_e = ($urandom_range(0, 6) == 0);
            set_fetch($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)],
                      1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)]);
            if ($urandom_range(0, 1) == 0) begin
                set_exec(1'b1, me.pt, me.pt ? me.ppc : pool[$urandom_range(0, 5)]);
            end else begin
                set_exec($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 2) == 0) ? me.ppc : pool[$urandom_range(0, 5)]);
            end
        end
        step();
        rst = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        set_fetch(1'b0, 32'd0, 1'b0, 32'd0);
        set_exec(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
